// File: rtl/branch_history_cache.sv
// Set-associative branch history cache. Each entry keeps a short taken/not-taken
// shift register. Reads are registered with one cycle of latency. Updates either
// shift the history of the matching entry, or allocate a new entry and replace
// the LRU way when the set is full.
module branch_history_cache #(
   parameter int PC_W     = 10,
   parameter int SET_BITS = 4,
   parameter int WAYS     = 2,  // 2 or 4
   parameter int HIST_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [PC_W-1:0]   pc,
   output logic [HIST_W-1:0] read_history,
   output logic              read_hit,
   input  logic              we,
   input  logic [PC_W-1:0]   update_pc,
   input  logic              branch_taken,
   output logic [HIST_W-1:0] update_history,
   output logic              evict,
   output logic [PC_W-1:0]   evict_pc
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int AGE_W = $clog2(WAYS);
   localparam int TAG_W = PC_W - SET_BITS;

   typedef logic [AGE_W-1:0] age_t;

   logic              valid_q [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [HIST_W-1:0] hist_q  [SETS][WAYS];
   age_t              age_q   [SETS][WAYS];

   logic [SET_BITS-1:0] rd_set, up_set;
   logic [TAG_W-1:0]    rd_tag, up_tag;

   assign rd_set = pc[SET_BITS-1:0];
   assign rd_tag = pc[PC_W-1:SET_BITS];
   assign up_set = update_pc[SET_BITS-1:0];
   assign up_tag = update_pc[PC_W-1:SET_BITS];

   logic              rd_hit;
   logic [HIST_W-1:0] rd_hist;

   // Lookup of the read port against the current array contents.
   always_comb begin
      rd_hit  = 1'b0;
      rd_hist = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[rd_set][w] && tag_q[rd_set][w] == rd_tag) begin
            rd_hit  = 1'b1;
            rd_hist = hist_q[rd_set][w];
         end
      end
   end

   logic              up_hit, inv_found, evict_now;
   age_t              hit_way, inv_way, lru_way, victim, old_age;
   logic [HIST_W:0]   hist_shift;
   logic [HIST_W-1:0] new_hist;

   // Selects the way touched by an update: the hit way, else the lowest invalid
   // way, else the way holding the oldest age.
   always_comb begin
      up_hit    = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
            up_hit  = 1'b1;
            hit_way = age_t'(w);
         end
         if (age_q[up_set][w] == age_t'(WAYS - 1))
            lru_way = age_t'(w);
      end
      // Scan downward so that the lowest-index invalid way is the one kept.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[up_set][w]) begin
            inv_found = 1'b1;
            inv_way   = age_t'(w);
         end
      end
      victim = up_hit ? hit_way : (inv_found ? inv_way : lru_way);
      // The recorded age of an invalid victim is used as its old age. Invalid
      // ways fill lowest-first from index-ordered ages, so this keeps the ages
      // of each set a permutation.
      old_age    = age_q[up_set][victim];
      hist_shift = {hist_q[up_set][victim], branch_taken};
      new_hist   = up_hit ? hist_shift[HIST_W-1:0] : HIST_W'(branch_taken);
      evict_now  = !up_hit && valid_q[up_set][victim];
   end

   // Array state, LRU ages and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               tag_q[s][w]   <= '0;
               hist_q[s][w]  <= '0;
               age_q[s][w]   <= age_t'(w);
            end
         end
         read_hit       <= 1'b0;
         read_history   <= '0;
         update_history <= '0;
         evict          <= 1'b0;
         evict_pc       <= '0;
      end else begin
         read_hit     <= flush ? 1'b0 : rd_hit;
         read_history <= flush ? '0 : rd_hist;
         evict        <= 1'b0;
         if (flush) begin
            for (int s = 0; s < SETS; s++) begin
               for (int w = 0; w < WAYS; w++) begin
                  valid_q[s][w] <= 1'b0;
                  age_q[s][w]   <= age_t'(w);
               end
            end
         end else if (we) begin
            valid_q[up_set][victim] <= 1'b1;
            tag_q[up_set][victim]   <= up_tag;
            hist_q[up_set][victim]  <= new_hist;
            for (int w = 0; w < WAYS; w++) begin
               if (age_t'(w) == victim)
                  age_q[up_set][w] <= '0;
               else if (age_q[up_set][w] < old_age)
                  age_q[up_set][w] <= age_q[up_set][w] + age_t'(1);
            end
            update_history <= new_hist;
            if (evict_now) begin
               evict    <= 1'b1;
               evict_pc <= {tag_q[up_set][victim], up_set};
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_history_cache.sv
// Directed bench for branch_history_cache with default parameters
// (PC_W=10, SET_BITS=4, WAYS=2, HIST_W=3).
module tb_branch_history_cache;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [9:0] pc = '0;
   logic [2:0] read_history;
   logic       read_hit;
   logic       we = 1'b0;
   logic [9:0] update_pc = '0;
   logic       branch_taken = 1'b0;
   logic [2:0] update_history;
   logic       evict;
   logic [9:0] evict_pc;

   branch_history_cache dut (
      .clk(clk), .rst(rst), .flush(flush), .pc(pc),
      .read_history(read_history), .read_hit(read_hit),
      .we(we), .update_pc(update_pc), .branch_taken(branch_taken),
      .update_history(update_history), .evict(evict), .evict_pc(evict_pc)
   );

   // Clock generation.
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] id;
      logic       hit;
      logic [2:0] rh;
      logic [2:0] uh;
      logic       ev;
      logic       chk_epc;
      logic [9:0] epc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   step_id = 0;

   // Drives one cycle of inputs and queues the outputs expected after that edge.
   task automatic step(input logic r, input logic f, input logic w,
                       input logic [9:0] p, input logic [9:0] up, input logic t,
                       input logic eh, input logic [2:0] erh, input logic [2:0] euh,
                       input logic eev, input logic ce, input logic [9:0] eepc);
      exp_t e;
      @(negedge clk);
      rst = r; flush = f; we = w; pc = p; update_pc = up; branch_taken = t;
      step_id++;
      e.id = 8'(step_id); e.hit = eh; e.rh = erh; e.uh = euh;
      e.ev = eev; e.chk_epc = ce; e.epc = eepc;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic chk(input string name, input int id, input logic [9:0] act, input logic [9:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, name, act, expv);
      end
   endtask

   // Monitor: after every edge, compare outputs against the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("read_hit", int'(e.id), 10'(read_hit), 10'(e.hit));
         chk("read_history", int'(e.id), 10'(read_history), 10'(e.rh));
         chk("update_history", int'(e.id), 10'(update_history), 10'(e.uh));
         chk("evict", int'(e.id), 10'(evict), 10'(e.ev));
         if (e.chk_epc) chk("evict_pc", int'(e.id), evict_pc, e.epc);
      end
   end

   initial begin
      //    rst  fl   we   pc      upc     t     hit  rh      uh      ev   ce   epc
      // Reset state, then first read misses.
      step(1'b1,1'b0,1'b0,10'h000,10'h000,1'b0, 1'b0,3'b000,3'b000,1'b0,1'b1,10'h000);
      step(1'b0,1'b0,1'b0,10'h004,10'h000,1'b0, 1'b0,3'b000,3'b000,1'b0,1'b0,10'h000);
      // History shifting on 0x004; read sees pre-update state.
      step(1'b0,1'b0,1'b1,10'h004,10'h004,1'b1, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h004,10'h004,1'b1, 1'b1,3'b001,3'b011,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h004,10'h004,1'b0, 1'b1,3'b011,3'b110,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b0,10'h004,10'h000,1'b0, 1'b1,3'b110,3'b110,1'b0,1'b0,10'h000);
      // Fill set 4, then evict the LRU entry 0x004.
      step(1'b0,1'b0,1'b1,10'h014,10'h014,1'b1, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h024,10'h024,1'b0, 1'b0,3'b000,3'b000,1'b1,1'b1,10'h004);
      step(1'b0,1'b0,1'b0,10'h014,10'h000,1'b0, 1'b1,3'b001,3'b000,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b0,10'h004,10'h000,1'b0, 1'b0,3'b000,3'b000,1'b0,1'b1,10'h004);
      // Set 5: touching 0x005 makes 0x015 the victim.
      step(1'b0,1'b0,1'b1,10'h000,10'h005,1'b1, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h000,10'h015,1'b1, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h000,10'h005,1'b1, 1'b0,3'b000,3'b011,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h000,10'h025,1'b1, 1'b0,3'b000,3'b001,1'b1,1'b1,10'h015);
      step(1'b0,1'b0,1'b0,10'h005,10'h000,1'b0, 1'b1,3'b011,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b0,10'h015,10'h000,1'b0, 1'b0,3'b000,3'b001,1'b0,1'b1,10'h015);
      // Same-cycle read and update of 0x006 with history 001.
      step(1'b0,1'b0,1'b1,10'h000,10'h006,1'b1, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h006,10'h006,1'b1, 1'b1,3'b001,3'b011,1'b0,1'b0,10'h000);
      // Back-to-back evictions in set 5 keep evict high.
      step(1'b0,1'b0,1'b1,10'h000,10'h035,1'b0, 1'b0,3'b000,3'b000,1'b1,1'b1,10'h005);
      step(1'b0,1'b0,1'b1,10'h000,10'h045,1'b1, 1'b0,3'b000,3'b001,1'b1,1'b1,10'h025);
      step(1'b0,1'b0,1'b0,10'h035,10'h000,1'b0, 1'b1,3'b000,3'b001,1'b0,1'b0,10'h000);
      // Flush with a same-cycle write: everything misses, no evict.
      step(1'b0,1'b1,1'b1,10'h006,10'h007,1'b1, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b0,10'h006,10'h000,1'b0, 1'b0,3'b000,3'b001,1'b0,1'b1,10'h025);
      step(1'b0,1'b0,1'b0,10'h045,10'h000,1'b0, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b0,10'h007,10'h000,1'b0, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b1,10'h014,10'h014,1'b1, 1'b0,3'b000,3'b001,1'b0,1'b0,10'h000);
      // Reset overrides a simultaneous flush and update.
      step(1'b1,1'b1,1'b1,10'h014,10'h016,1'b1, 1'b0,3'b000,3'b000,1'b0,1'b1,10'h000);
      step(1'b0,1'b0,1'b0,10'h014,10'h000,1'b0, 1'b0,3'b000,3'b000,1'b0,1'b0,10'h000);
      step(1'b0,1'b0,1'b0,10'h016,10'h000,1'b0, 1'b0,3'b000,3'b000,1'b0,1'b0,10'h000);
      @(negedge clk);
      we = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
